// File: rtl/ysyx_25060173_pkg.sv
// Shared constants for the NPC front end: data width, reset PC,
// IFU state encoding and instruction size.
package ysyx_25060173_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          INST_BYTES = 4;

  // IFU state encoding, kept as plain 2-bit constants so older blocks can
  // compare against them directly.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  typedef logic [1:0] ifu_state_t;

endpackage

// File: rtl/ysyx_25060173_ifu_if.sv
// Bus bundle around the IFU: fetch request/response to instruction memory,
// the valid/ready instruction output to decode, and the redirect input.
// master = IFU side, slave = environment (memory, decode, execute).
interface ysyx_25060173_ifu_if #(
  parameter int XLEN = ysyx_25060173_pkg::XLEN
);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_err;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output out_valid, out_pc, out_inst, out_err,
    input  out_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  out_valid, out_pc, out_inst, out_err,
    output out_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_25060173_Reg.sv
// Generic register with write enable and synchronous active-high reset.
module ysyx_25060173_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Load reset value on rst, otherwise capture din when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_25060173_ifu.sv
// Multi-cycle instruction fetch unit. One outstanding fetch at a time:
// S_REQ issues the word fetch, S_WAIT waits for the response, S_OUT holds
// the instruction until decode takes it. A redirect wins in every state;
// a fetch already in flight when the redirect arrives is marked stale
// (kill) and its response is dropped on return.
module ysyx_25060173_ifu
  import ysyx_25060173_pkg::*;
#(
  parameter int               XLEN     = ysyx_25060173_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = ysyx_25060173_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_25060173_ifu_if.master   bus
);

  ifu_state_t      state_q, state_d;
  logic            kill_q, kill_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_inst_q, out_inst_d;
  logic            out_err_q, out_err_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_wen;
  logic            req_fire;
  logic [XLEN-1:0] redirect_aligned;

  ysyx_25060173_Reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (pc_wen),
    .din  (pc_d),
    .dout (pc_q)
  );

  // No request while reset is held or while the PC is being redirected.
  assign bus.req_valid = (state_q == S_REQ) && !bus.redirect_valid && !rst;
  assign bus.req_addr  = pc_q;
  assign req_fire      = bus.req_valid && bus.req_ready;

  assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_err   = out_err_q;

  // Next-state logic: redirect first, then the normal fetch sequence.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    pc_d        = pc_q;
    pc_wen      = 1'b0;

    if (bus.redirect_valid) begin
      pc_d   = redirect_aligned;
      pc_wen = 1'b1;
      case (state_q)
        S_REQ: begin
          state_d = S_REQ;
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            // Response in the redirect cycle is simply discarded.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end
        S_OUT: begin
          // The held instruction is abandoned, not consumed.
          out_valid_d = 1'b0;
          state_d     = S_REQ;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              out_inst_d  = bus.rsp_data;
              out_err_d   = bus.rsp_err;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              state_d     = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_valid_q && bus.out_ready) begin
            pc_d        = pc_q + XLEN'(INST_BYTES);
            pc_wen      = 1'b1;
            out_valid_d = 1'b0;
            state_d     = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // State and output latches; reset restores the idle, empty front end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Directed bench for the IFU: a cycle-by-cycle vector table plus one
// hand-written variable-latency fetch.
module tb_ysyx_25060173_ifu;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ysyx_25060173_ifu_if #(.XLEN(32)) bus ();

  ysyx_25060173_ifu #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        out_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_out_valid;
    logic [31:0] e_out_pc;
    logic [31:0] e_out_inst;
    logic        e_out_err;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   outstanding = 1'b0;

  function automatic vec_t mk(
    input string name,
    input logic r, input logic rr, input logic rv, input logic [31:0] rd,
    input logic re, input logic ordy, input logic rdv, input logic [31:0] rpc,
    input logic e_rv, input logic [31:0] e_addr, input logic e_ov,
    input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_err);
    vec_t v;
    v.name = name; v.rst = r; v.req_ready = rr; v.rsp_valid = rv;
    v.rsp_data = rd; v.rsp_err = re; v.out_ready = ordy; v.redir = rdv;
    v.redir_pc = rpc; v.e_req_valid = e_rv; v.e_req_addr = e_addr;
    v.e_out_valid = e_ov; v.e_out_pc = e_pc; v.e_out_inst = e_inst;
    v.e_out_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = 32'h0;
    bus.rsp_err        = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst                = v.rst;
    bus.req_ready      = v.req_ready;
    bus.rsp_valid      = v.rsp_valid;
    bus.rsp_data       = v.rsp_data;
    bus.rsp_err        = v.rsp_err;
    bus.out_ready      = v.out_ready;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.redir_pc;
    #1;
    if (v.rsp_valid && !v.rst) begin
      chk({v.name, ".rsp_in_wait"}, {31'd0, outstanding}, 32'd1);
    end
    chk({v.name, ".req_valid"}, {31'd0, bus.req_valid}, {31'd0, v.e_req_valid});
    chk({v.name, ".req_addr"},  bus.req_addr,           v.e_req_addr);
    chk({v.name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v.e_out_valid});
    chk({v.name, ".out_pc"},    bus.out_pc,             v.e_out_pc);
    chk({v.name, ".out_inst"},  bus.out_inst,           v.e_out_inst);
    chk({v.name, ".out_err"},   {31'd0, bus.out_err},   {31'd0, v.e_out_err});
    $display("[TB] vec %0d %s: req_valid=%0b addr=%08h out_valid=%0b pc=%08h inst=%08h err=%0b",
             idx, v.name, bus.req_valid, bus.req_addr, bus.out_valid,
             bus.out_pc, bus.out_inst, bus.out_err);
    if (v.rst) outstanding = 1'b0;
    else if (v.rsp_valid) outstanding = 1'b0;
    else if (bus.req_valid && bus.req_ready) outstanding = 1'b1;
  endtask

  initial begin
    int waited;
    bit seen;

    rst = 1'b1;
    drive_idle();
    @(posedge clk);

    //             name        rst rr rv rdata          re or rd rpc            e_rv e_addr         e_ov e_pc           e_inst         e_err
    vecs.push_back(mk("rst",     1, 0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 32'h0,          32'h0,         0));
    vecs.push_back(mk("req0",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0000, 0, 32'h0,          32'h0,         0));
    vecs.push_back(mk("rsp0",    0, 0, 1, 32'h0000_0413, 0, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 32'h0,          32'h0,         0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("hold",  0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("take0",   0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("req1n",   0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0004, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("req1",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0004, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("rdrW",    0, 0, 0, 32'h0,         0, 0, 1, 32'h8000_0102,  0, 32'h8000_0004, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("killw1",  0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h8000_0100, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("killw2",  0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h8000_0100, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("stale",   0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,          0, 32'h8000_0100, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("req2",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0100, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("rsp2",    0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,          0, 32'h8000_0100, 0, 32'h8000_0000, 32'h0000_0413, 0));
    vecs.push_back(mk("rdrO",    0, 0, 0, 32'h0,         0, 1, 1, 32'h8000_0200,  0, 32'h8000_0100, 1, 32'h8000_0100, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("req3n",   0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0200, 0, 32'h8000_0100, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("rdrR",    0, 1, 0, 32'h0,         0, 0, 1, 32'h8000_0300,  0, 32'h8000_0200, 0, 32'h8000_0100, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("req4",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0300, 0, 32'h8000_0100, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("rspErr",  0, 0, 1, 32'h0,         1, 0, 0, 32'h0,          0, 32'h8000_0300, 0, 32'h8000_0100, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("takeErr", 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 32'h8000_0300, 1, 32'h8000_0300, 32'h0,         1));
    vecs.push_back(mk("req5",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0304, 0, 32'h8000_0300, 32'h0,         1));
    vecs.push_back(mk("rsp5",    0, 0, 1, 32'h0010_0093, 0, 0, 0, 32'h0,          0, 32'h8000_0304, 0, 32'h8000_0300, 32'h0,         1));
    vecs.push_back(mk("take5",   0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 32'h8000_0304, 1, 32'h8000_0304, 32'h0010_0093, 0));
    vecs.push_back(mk("req6",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0308, 0, 32'h8000_0304, 32'h0010_0093, 0));
    vecs.push_back(mk("rdrWrsp", 0, 0, 1, 32'h1111_1111, 0, 0, 1, 32'h8000_0400,  0, 32'h8000_0308, 0, 32'h8000_0304, 32'h0010_0093, 0));
    vecs.push_back(mk("req7",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0400, 0, 32'h8000_0304, 32'h0010_0093, 0));
    vecs.push_back(mk("rsp7",    0, 0, 1, 32'h2222_2222, 0, 0, 0, 32'h0,          0, 32'h8000_0400, 0, 32'h8000_0304, 32'h0010_0093, 0));
    vecs.push_back(mk("take7",   0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 32'h8000_0400, 1, 32'h8000_0400, 32'h2222_2222, 0));
    vecs.push_back(mk("req8",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0404, 0, 32'h8000_0400, 32'h2222_2222, 0));
    vecs.push_back(mk("rstW",    1, 1, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h8000_0404, 0, 32'h8000_0400, 32'h2222_2222, 0));
    vecs.push_back(mk("postRst", 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h8000_0000, 0, 32'h0,          32'h0,         0));
    vecs.push_back(mk("rdrTop",  0, 0, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFF,  0, 32'h8000_0000, 0, 32'h0,          32'h0,         0));
    vecs.push_back(mk("req9",    0, 1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,         0));
    vecs.push_back(mk("rsp9",    0, 0, 1, 32'h3333_3333, 0, 0, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,         0));
    vecs.push_back(mk("take9",   0, 0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h3333_3333, 0));
    vecs.push_back(mk("wrap",    0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h3333_3333, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Variable-latency memory: accept at pc=0, respond after 3 idle cycles,
    // instruction must appear exactly one cycle after the response.
    @(negedge clk);
    drive_idle();
    bus.req_ready = 1'b1;
    #1;
    chk("lat.req_valid", {31'd0, bus.req_valid}, 32'd1);
    chk("lat.req_addr", bus.req_addr, 32'h0000_0000);
    $display("[TB] lat accept: addr=%08h", bus.req_addr);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle();
      #1;
      chk("lat.wait_req_valid", {31'd0, bus.req_valid}, 32'd0);
      chk("lat.wait_out_valid", {31'd0, bus.out_valid}, 32'd0);
      $display("[TB] lat wait %0d: out_valid=%0b", i, bus.out_valid);
    end
    @(negedge clk);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 32'h4444_4444;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 8) begin
      @(negedge clk);
      drive_idle();
      #1;
      waited++;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("lat.out_seen", {31'd0, seen}, 32'd1);
    chk("lat.latency", waited, 32'd1);
    chk("lat.out_pc", bus.out_pc, 32'h0000_0000);
    chk("lat.out_inst", bus.out_inst, 32'h4444_4444);
    $display("[TB] lat out: waited=%0d pc=%08h inst=%08h", waited, bus.out_pc, bus.out_inst);
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive_idle();
    #1;
    chk("lat.next_addr", bus.req_addr, 32'h0000_0004);
    chk("lat.next_out_valid", {31'd0, bus.out_valid}, 32'd0);
    $display("[TB] lat consume: next addr=%08h", bus.req_addr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
